// File: rtl/u8_uart_pkg.sv
// rtl/u8_uart_pkg.sv - shared UART framing constants and transmitter state type
package u8_uart_pkg;

  localparam int UART_CLKDIV_DEFAULT = 16;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_FETCH = 3'd1,
    TX_START = 3'd2,
    TX_DATA  = 3'd3,
    TX_STOP  = 3'd4
  } uart_tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - free-running 0..CLKDIV-1 bit timer with clear and terminal count
module uart_bit_timer
  import u8_uart_pkg::*;
#(
  parameter int CLKDIV = UART_CLKDIV_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tc
);

  localparam int TW = $clog2(CLKDIV);
  localparam logic [TW-1:0] LAST = TW'(CLKDIV - 1);

  logic [TW-1:0] count;

  assign tc = (count == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || tc) begin
      count <= '0;
    end else begin
      count <= count + TW'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops bytes from a registered-read FIFO and sends them as 8N1 frames
module fifo_uart_tx
  import u8_uart_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int CLKDIV = UART_CLKDIV_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_dequeue,
  output logic             tx,
  output logic             busy
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

  uart_tx_state_t   state;
  logic [WIDTH-1:0] shift;
  logic [IW-1:0]    bit_idx;
  logic             timer_clear;
  logic             timer_tc;

  // reset is folded in so no pop can escape while the block is held in reset
  assign fifo_dequeue = (state == TX_IDLE) && enable && !fifo_empty && reset;
  assign busy         = (state != TX_IDLE);

  // holding the timer clear through IDLE/FETCH makes it start at 0 on START entry;
  // every later transition lands on a terminal count, where it wraps to 0 anyway
  assign timer_clear = (state == TX_IDLE) || (state == TX_FETCH);

  uart_bit_timer #(
    .CLKDIV(CLKDIV)
  ) u_bit_timer (
    .clock(clock),
    .reset(reset),
    .clear(timer_clear),
    .tc   (timer_tc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= TX_IDLE;
      tx      <= 1'b1;
      shift   <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (fifo_dequeue) state <= TX_FETCH;
        end
        TX_FETCH: begin
          shift <= fifo_data;
          tx    <= 1'b0;
          state <= TX_START;
        end
        TX_START: begin
          if (timer_tc) begin
            tx      <= shift[0];
            bit_idx <= '0;
            state   <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (timer_tc) begin
            shift <= shift >> 1;
            if (bit_idx == LAST_BIT) begin
              tx      <= 1'b1;
              bit_idx <= '0;
              state   <= TX_STOP;
            end else begin
              tx      <= shift[1];
              bit_idx <= bit_idx + IW'(1);
            end
          end
        end
        TX_STOP: begin
          if (timer_tc) state <= TX_IDLE;
        end
        default: begin
          state <= TX_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx against a frame-level model
module tb_fifo_uart_tx;

  localparam int WIDTH  = 8;
  localparam int CLKDIV = 4;
  localparam int FRAME  = (WIDTH + 2) * CLKDIV + 2;
  localparam int NEVER  = 1 << 30;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] fifo_data = '0;
  logic             fifo_dequeue;
  logic             tx;
  logic             busy;

  logic [WIDTH-1:0] q[$];
  int n_checks = 0;
  int n_errors = 0;

  fifo_uart_tx #(
    .WIDTH (WIDTH),
    .CLKDIV(CLKDIV)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_dequeue(fifo_dequeue),
    .tx          (tx),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  // Frame model: a pop at cycle p puts the start bit at p+2..p+1+CLKDIV, data bit i
  // at p+2+CLKDIV*(i+1) for CLKDIV cycles, stop bit after, busy from p+1 for 1+(WIDTH+2)*CLKDIV.
  task automatic run_check(input string name, input int ncyc, input int drop);
    logic             e_tx [0:299];
    logic             e_busy [0:299];
    logic             e_deq [0:299];
    logic [WIDTH-1:0] pending[$];
    logic [WIDTH-1:0] b;
    int               t;
    int               k;
    logic             pop_now;
    pending = q;
    for (int c = 0; c < ncyc; c++) begin
      e_tx[c] = 1'b1; e_busy[c] = 1'b0; e_deq[c] = 1'b0;
    end
    t = 0;
    while (pending.size() > 0 && t < ncyc && t < drop) begin
      b = pending.pop_front();
      e_deq[t] = 1'b1;
      for (int j = 1; j <= (WIDTH + 2) * CLKDIV + 1; j++) begin
        k = t + j;
        if (k < ncyc) begin
          e_busy[k] = 1'b1;
          if (j >= 2 && j < 2 + CLKDIV) e_tx[k] = 1'b0;
          else if (j >= 2 + CLKDIV && j < 2 + (WIDTH + 1) * CLKDIV)
            e_tx[k] = b[(j - 2 - CLKDIV) / CLKDIV];
        end
      end
      t += FRAME;
    end
    for (int c = 0; c < ncyc; c++) begin
      if (c == drop) enable = 1'b0;
      @(negedge clock);
      n_checks += 3;
      if (tx !== e_tx[c]) begin
        n_errors++;
        $display("FAIL %s tx cycle %0d: got %b want %b", name, c, tx, e_tx[c]);
      end
      if (busy !== e_busy[c]) begin
        n_errors++;
        $display("FAIL %s busy cycle %0d: got %b want %b", name, c, busy, e_busy[c]);
      end
      if (fifo_dequeue !== e_deq[c]) begin
        n_errors++;
        $display("FAIL %s fifo_dequeue cycle %0d: got %b want %b", name, c, fifo_dequeue, e_deq[c]);
      end
      pop_now = fifo_dequeue;
      @(posedge clock);
      #1;
      if (pop_now && q.size() > 0) fifo_data = q.pop_front();
      fifo_empty = (q.size() == 0);
    end
    n_checks++;
    if (q.size() != pending.size()) begin
      n_errors++;
      $display("FAIL %s fifo_level: got %0d want %0d", name, q.size(), pending.size());
    end
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] b);
    q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    enable = 1'b1;
    load(8'h3C);
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      n_checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_dequeue !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_hold cycle %0d: tx=%b busy=%b deq=%b want 1 0 0", c, tx, busy, fifo_dequeue);
      end
    end
    @(posedge clock);
    #1;
    q.delete();
    fifo_empty = 1'b1;
  endtask

  task automatic test_single();
    hold_reset();
    enable = 1'b1;
    load(8'hA5);
    reset = 1'b1;
    run_check("single_a5", 60, NEVER);
  endtask

  task automatic test_back_to_back();
    hold_reset();
    enable = 1'b1;
    load(8'h00);
    load(8'hFF);
    reset = 1'b1;
    run_check("b2b_00_ff", 100, NEVER);
  endtask

  task automatic test_random_frames();
    int n;
    hold_reset();
    enable = 1'b1;
    n = $urandom_range(2, 4);
    for (int i = 0; i < n; i++) load(WIDTH'($urandom));
    reset = 1'b1;
    run_check("random_frames", n * FRAME + 10, NEVER);
  endtask

  task automatic test_enable_drop();
    hold_reset();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) load(WIDTH'($urandom));
    reset = 1'b1;
    run_check("enable_drop", 2 * FRAME + 20, 10);
    q.delete();
    fifo_empty = 1'b1;
  endtask

  task automatic test_reset_mid_data();
    logic [WIDTH-1:0] b2;
    hold_reset();
    enable = 1'b1;
    load(WIDTH'($urandom) & ~WIDTH'(8));
    b2 = WIDTH'($urandom);
    load(b2);
    reset = 1'b1;
    run_check("pre_reset", 20, NEVER);
    #2;
    reset = 1'b0;
    #1;
    n_checks += 2;
    if (tx !== 1'b1) begin
      n_errors++;
      $display("FAIL async_reset tx: got %b want 1", tx);
    end
    if (busy !== 1'b0 || fifo_dequeue !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset busy/deq: got %b/%b want 0/0", busy, fifo_dequeue);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    run_check("post_reset", FRAME + 10, NEVER);
  endtask

  task automatic test_empty();
    hold_reset();
    enable = 1'b1;
    q.delete();
    fifo_empty = 1'b1;
    reset = 1'b1;
    run_check("empty_fifo", 100, NEVER);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random_frames();
    test_enable_drop();
    test_reset_mid_data();
    test_empty();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Drains bytes from a synchronous FIFO with a registered read port and serializes each one as an asynchronous 8N1-style frame on a single line. It is the consumer for the FIFO used as a transmit buffer in the memio subsystem: the CPU side enqueues, and this block dequeues and shifts out.

## Interface
- `WIDTH`, 8: data bits per frame; must equal the FIFO data width.
- `CLKDIV`, 16: clock cycles per serial bit; must be ≥ 2.
- `clock`  in  1  sole clock; every register is updated on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  permits new frames to start; sampled only in IDLE.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  WIDTH  FIFO read data; valid the cycle after a dequeue.
- `fifo_dequeue`  out  1  one-cycle pop strobe to the FIFO.
- `tx`  out  1  serial line, registered; idles high.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, FETCH, START, DATA, STOP.
- IDLE: `tx`=1. `fifo_dequeue` = `enable && !fifo_empty && reset` (combinational). If asserted, next state is FETCH.
- FETCH: lasts 1 cycle. `fifo_data` is valid. At the closing edge, load the shift register with `fifo_data`, drive `tx` to 0, and go to START.
- START: `tx`=0 for CLKDIV cycles. At the closing edge, drive `tx` to `shift[0]` and go to DATA.
- DATA: WIDTH bits, LSB first, CLKDIV cycles each. At each bit boundary the shift register shifts right and the bit index increments. After bit WIDTH-1, drive `tx` to 1 and go to STOP.
- STOP: `tx`=1 for CLKDIV cycles, then go to IDLE.
- The bit timer counts 0..CLKDIV-1 and clears on every state entry. The bit index is $clog2(WIDTH) wide. The timer width is $clog2(CLKDIV).
- Dropping `enable` mid-frame does not abort the frame. The current frame completes and no further pop occurs.
- `fifo_empty` is ignored outside IDLE. `fifo_dequeue` is never asserted outside IDLE.
- Exactly one pop occurs per frame. There is no pop while `fifo_empty`=1.

## Timing
- Reset values: state=IDLE, `tx`=1, `busy`=0, `fifo_dequeue`=0, timer=0, bit index=0, shift register=0.
- Reset mid-frame forces `tx` high asynchronously and abandons the byte; it is not retransmitted.
- Pop-to-start latency: if the pop occurs in cycle n, `tx` falls at the edge ending cycle n+1.
- `busy` is high from cycle n+1 through the last STOP cycle, for 1 + (WIDTH+2)·CLKDIV cycles.
- Back-to-back frames: the next pop occurs in the first IDLE cycle after STOP.
- Start-bit period for back-to-back frames is (WIDTH+2)·CLKDIV + 2 cycles. The line stays high for CLKDIV+2 cycles between frames.
- After `reset` deasserts, the first pop can occur in the first cycle after release.

## Structure
- Shared package `u8_uart_pkg` holds:
  - the state enum typedef `uart_tx_state_t` (IDLE, FETCH, START, DATA, STOP);
  - the default CLKDIV constant, so the matching receiver uses the same framing.
- Natural sub-module: `uart_bit_timer`, a CLKDIV counter with a clear input and a terminal-count output. It is reused by the receiver.
- The FSM, shift register and bit index stay in `fifo_uart_tx`.

## Test plan
Parameters WIDTH=8 and CLKDIV=4 throughout.
- Reset: hold `reset`=0 with `fifo_empty`=0 and `enable`=1 → `tx`=1, `busy`=0, `fifo_dequeue`=0 for the whole duration.
- Single byte: FIFO holds 0xA5 and the pop occurs in cycle 0 →
  - `fifo_dequeue` is high in cycle 0 only;
  - `tx` is 0 in cycles 2–5;
  - data bits 1,0,1,0,0,1,0,1 occupy cycles 6–37, 4 cycles each;
  - `tx` is 1 in cycles 38–41;
  - `busy` is high in cycles 1–41.
- Back-to-back: FIFO holds 0x00 then 0xFF →
  - pops occur in cycles 0 and 42;
  - start bits begin in cycles 2 and 44;
  - second frame's data is 1 in cycles 48–79.
- Enable drop: deassert `enable` in cycle 10 of a frame, with the FIFO still non-empty → the frame completes unchanged, then `fifo_dequeue` stays 0 and `tx` stays 1.
- Reset mid-DATA: assert `reset`=0 in cycle 20 → `tx`=1 and `busy`=0 without a clock edge. After release, the next byte pops on the first clock.
- Empty FIFO: `enable`=1 and `fifo_empty`=1 for 100 cycles → no pop, `tx`=1, `busy`=0.
